async_hs_bridge: RTL

Clocked endpoint of the four-phase req/ack control network. It terminates one output channel of the self-timed pipeline as a handshake receiver and drives one input channel as a handshake initiator, converting both to valid/ready on the clocked side. It replaces a free-running `req_rst` kick with counted, clocked token injection. It also returns each completed token, for example from the `rfw` stage, to synchronous logic.

---
 rtl/async_hs_bridge_pkg.sv | 28 ++
 rtl/async_hs_bridge_sync.sv | 34 +++
 rtl/async_hs_bridge.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/async_hs_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : async_pkg                                              |
// | Description : Shared state types and defaults for the clocked        |
// |               endpoint of the four-phase req/ack control network.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package async_pkg;

  // Default flop depth of each asynchronous-input synchronizer.
  localparam int unsigned SYNC_STAGES_DEF = 2;

  // Channel A receiver: wait for request, offer token, hold acknowledge.
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_PEND = 2'd1,
    R_ACK  = 2'd2
  } rx_state_e;

  // Channel B initiator: idle, request high, request low awaiting ack low.
  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_RISE = 2'd1,
    T_FALL = 2'd2
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/async_hs_bridge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : hs_sync                                                |
// | Description : N-flop synchronizer for one asynchronous control bit,  |
// |               asynchronous active-low reset to 0.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module hs_sync
  import async_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain; the last flop is the
  // only one the rest of the design may look at.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_i};
    end
  end

  assign q_o = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/async_hs_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : async_hs_bridge                                        |
// | Description : Four-phase req/ack to valid/ready bridge. Channel A is |
// |               received into a clocked token stream, channel B is     |
// |               driven from clocked launch requests; tokens in flight  |
// |               are counted and handshake stalls are flagged.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module async_hs_bridge
  import async_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned TMO_W       = 8,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_a_i,
  output logic             ack_a_o,
  output logic             req_b_o,
  input  logic             ack_b_i,
  output logic             tok_valid_o,
  input  logic             tok_ready_i,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  output logic [CNT_W-1:0] inflight_o,
  output logic             err_tmo_o,
  output logic             err_cnt_o,
  input  logic             err_clr_i
);

  localparam logic [TMO_W-1:0] c_tmo_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic             w_req_a_s;
  logic             w_ack_b_s;
  rx_state_e        r_rx_state;
  rx_state_e        w_rx_next;
  tx_state_e        r_tx_state;
  tx_state_e        w_tx_next;
  logic             r_ack_a;
  logic             r_tok_valid;
  logic             r_req_b;
  logic             r_issue_ready;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [TMO_W-1:0] w_tmo_next;
  logic             w_tmo_set;
  logic [CNT_W-1:0] r_inflight;
  logic [CNT_W-1:0] w_inflight_next;
  logic             w_cnt_set;
  logic             w_issue_acc;
  logic             w_tok_acc;
  logic             r_err_tmo;
  logic             r_err_cnt;

  hs_sync #(.STAGES(SYNC_STAGES)) u_sync_req_a (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (req_a_i),
    .q_o    (w_req_a_s)
  );

  hs_sync #(.STAGES(SYNC_STAGES)) u_sync_ack_b (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (ack_b_i),
    .q_o    (w_ack_b_s)
  );

  assign w_issue_acc = (r_tx_state == T_IDLE) && issue_valid_i;
  assign w_tok_acc   = (r_rx_state == R_PEND) && tok_ready_i;

  // Receiver next state: offer the token once the request is seen, acknowledge
  // after the consumer takes it, release when the request returns to zero.
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      R_IDLE:  if (w_req_a_s)   w_rx_next = R_PEND;
      R_PEND:  if (tok_ready_i) w_rx_next = R_ACK;
      R_ACK:   if (!w_req_a_s)  w_rx_next = R_IDLE;
      default: w_rx_next = R_IDLE;
    endcase
  end

  // Transmitter next state: one full four-phase cycle per accepted launch.
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      T_IDLE:  if (issue_valid_i) w_tx_next = T_RISE;
      T_RISE:  if (w_ack_b_s)     w_tx_next = T_FALL;
      T_FALL:  if (!w_ack_b_s)    w_tx_next = T_IDLE;
      default: w_tx_next = T_IDLE;
    endcase
  end

  // Handshake stall timer: restarts on every phase change and on a flag clear,
  // so a handshake that stays stuck re-reports after another full period.
  always_comb begin
    w_tmo_next = r_tmo_cnt;
    if ((w_tx_next != r_tx_state) || err_clr_i) begin
      w_tmo_next = '0;
    end else if ((r_tx_state != T_IDLE) && (r_tmo_cnt != c_tmo_max)) begin
      w_tmo_next = r_tmo_cnt + TMO_W'(1);
    end
    w_tmo_set = (w_tmo_next == c_tmo_max);
  end

  // In-flight token count with saturation at both ends; a blocked step flags.
  always_comb begin
    w_inflight_next = r_inflight;
    w_cnt_set       = 1'b0;
    if (w_issue_acc && !w_tok_acc) begin
      if (r_inflight == c_cnt_max) w_cnt_set = 1'b1;
      else                         w_inflight_next = r_inflight + CNT_W'(1);
    end else if (w_tok_acc && !w_issue_acc) begin
      if (r_inflight == '0) w_cnt_set = 1'b1;
      else                  w_inflight_next = r_inflight - CNT_W'(1);
    end
  end

  // State registers and output flops; outputs are decoded from the next state
  // so every port is driven straight from a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_state    <= R_IDLE;
      r_tx_state    <= T_IDLE;
      r_ack_a       <= 1'b0;
      r_tok_valid   <= 1'b0;
      r_req_b       <= 1'b0;
      r_issue_ready <= 1'b1;
      r_tmo_cnt     <= '0;
      r_inflight    <= '0;
    end else begin
      r_rx_state    <= w_rx_next;
      r_tx_state    <= w_tx_next;
      r_ack_a       <= (w_rx_next == R_ACK);
      r_tok_valid   <= (w_rx_next == R_PEND);
      r_req_b       <= (w_tx_next == T_RISE);
      r_issue_ready <= (w_tx_next == T_IDLE);
      r_tmo_cnt     <= w_tmo_next;
      r_inflight    <= w_inflight_next;
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_tmo <= 1'b0;
      r_err_cnt <= 1'b0;
    end else begin
      if (w_tmo_set)      r_err_tmo <= 1'b1;
      else if (err_clr_i) r_err_tmo <= 1'b0;
      if (w_cnt_set)      r_err_cnt <= 1'b1;
      else if (err_clr_i) r_err_cnt <= 1'b0;
    end
  end

  assign ack_a_o       = r_ack_a;
  assign tok_valid_o   = r_tok_valid;
  assign req_b_o       = r_req_b;
  assign issue_ready_o = r_issue_ready;
  assign inflight_o    = r_inflight;
  assign err_tmo_o     = r_err_tmo;
  assign err_cnt_o     = r_err_cnt;

endmodule
`default_nettype wire
